// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the uart_tx arbiter and its rotating-priority finder.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRAIN = 2'd2
  } arb_state_t;

  localparam logic [7:0] TAG_BASE = 8'hA0;
  localparam int         TMO_W    = 20;

endpackage

// File: rtl/uart_tx_rr_pick.sv
// Rotating-priority finder: first set request at or above ptr, wrapping past NUM_SRC-1 to 0.
module uart_tx_rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  localparam int CW = IDX_W + 1;
  localparam logic [CW-1:0] NSRC_C = CW'(NUM_SRC);

  logic [CW-1:0] cand;
  logic          found;

  // Wrap is an explicit subtract so non-power-of-two source counts stay in range.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= NSRC_C) cand = cand - NSRC_C;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx byte port among NUM_SRC sources.
// Define UART_TX_ARB_SRC_TAG_EN to prefix every granted packet with tag byte TAG_BASE | grant_id.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*8-1:0]       src_data,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC-1:0]         src_last,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_pulse,
  output logic [1:0]                 state_dbg
);

  // Handshakes: a byte moves on a clk edge where valid and ready are both high. tx_valid holds
  // tx_data steady until that edge; a source may withdraw src_valid, which only feeds the timeout.

  localparam int GW = $clog2(NUM_SRC);
  localparam logic [GW-1:0]    LAST_IDX  = GW'(NUM_SRC - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC - 1);

  arb_state_t       state, state_nxt;
  logic [GW-1:0]    grant_q, grant_nxt;
  logic [GW-1:0]    rr_q, rr_nxt;
  logic [TMO_W-1:0] tmo_q, tmo_nxt;
  logic [7:0]       tx_data_nxt;
  logic             tx_valid_nxt;
  logic             pulse_nxt;

  logic [GW-1:0]    pick_idx;
  logic             any_req;
  logic             g_valid, g_last;
  logic [7:0]       g_data;
  logic             accept, tx_hs, stall;
  logic [GW-1:0]    next_ptr;

  uart_tx_rr_pick #(.NUM_SRC(NUM_SRC), .IDX_W(GW)) u_pick (
    .req     (src_valid),
    .ptr     (rr_q),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  assign g_valid  = src_valid[grant_q];
  assign g_last   = src_last[grant_q];
  assign g_data   = src_data[int'(grant_q)*8 +: 8];
  assign accept   = rst_n && (state == S_GRANT) && !tx_valid && g_valid;
  assign tx_hs    = tx_valid && tx_ready;
  assign stall    = !tx_valid && !g_valid;
  assign next_ptr = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

  always_comb begin
    src_ready = '0;
    if (accept) src_ready[grant_q] = 1'b1;
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_q;
    rr_nxt       = rr_q;
    tmo_nxt      = tmo_q;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    pulse_nxt    = 1'b0;

    if (tx_hs) tx_valid_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (any_req) begin
          grant_nxt = pick_idx;
          tmo_nxt   = '0;
          state_nxt = S_GRANT;
`ifdef UART_TX_ARB_SRC_TAG_EN
          // The tag occupies the holding register, so payload and timeout wait for its handshake.
          tx_data_nxt  = TAG_BASE | {{(8-GW){1'b0}}, pick_idx};
          tx_valid_nxt = 1'b1;
`endif
        end
      end
      S_GRANT: begin
        if (accept) begin
          tx_data_nxt  = g_data;
          tx_valid_nxt = 1'b1;
          tmo_nxt      = '0;
          if (g_last) state_nxt = S_DRAIN;
        end else if (stall) begin
          if (tmo_q == TMO_LIMIT) begin
            pulse_nxt = 1'b1;
            rr_nxt    = next_ptr;
            state_nxt = S_IDLE;
          end else begin
            tmo_nxt = tmo_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (tx_hs) begin
          rr_nxt    = next_ptr;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      grant_q       <= '0;
      rr_q          <= '0;
      tmo_q         <= '0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      grant_q       <= grant_nxt;
      rr_q          <= rr_nxt;
      tmo_q         <= tmo_nxt;
      tx_data       <= tx_data_nxt;
      tx_valid      <= tx_valid_nxt;
      timeout_pulse <= pulse_nxt;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: packet-level reference model, uart_tx busy model,
// per-source drivers and a byte/grant scoreboard.
module tb_uart_tx_arbiter;

  localparam int NS       = 4;
  localparam int TMO      = 16;
  localparam int BAUD_DIV = 4;
  localparam int DEPTH    = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NS*8-1:0] src_data;
  logic [NS-1:0]   src_valid, src_last, src_ready;
  logic [7:0]      tx_data;
  logic            tx_valid, tx_ready;
  logic [1:0]      grant_id;
  logic            busy, timeout_pulse;
  logic [1:0]      state_dbg;

  uart_tx_arbiter #(.NUM_SRC(NS), .TIMEOUT_CYC(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_data      (src_data),
    .src_valid     (src_valid),
    .src_last      (src_last),
    .src_ready     (src_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .state_dbg     (state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx stand-in: idle accepts a byte, then stays busy for one 10-bit frame.
  int uart_cnt = 0;
  assign tx_ready = (uart_cnt == 0);
  always @(posedge clk) begin
    if (!rst_n)                   uart_cnt <= 0;
    else if (tx_valid && tx_ready) uart_cnt <= BAUD_DIV * 10;
    else if (uart_cnt > 0)         uart_cnt <= uart_cnt - 1;
  end

  // ---------------- check task ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver storage ----------------
  logic [8:0] drv_mem[NS][DEPTH];
  int drv_head[NS], drv_tail[NS], drv_hold[NS], ready_cnt[NS];

  function automatic bit drv_empty();
    for (int i = 0; i < NS; i++) if (drv_head[i] != drv_tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic [NS-1:0] acc;
    for (int i = 0; i < NS; i++) begin
      drv_head[i] = 0; drv_tail[i] = 0; drv_hold[i] = 0; ready_cnt[i] = 0;
    end
    src_valid = '0; src_last = '0; src_data = '0;
    forever begin
      @(negedge clk);
      acc = src_valid & src_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (acc[i]) begin
          ready_cnt[i]++;
          drv_hold[i] = drv_mem[i][drv_head[i] % DEPTH][8] ? 0 : $urandom_range(0, 3);
          drv_head[i]++;
        end else if (drv_hold[i] > 0) begin
          drv_hold[i]--;
        end
        if (drv_head[i] != drv_tail[i] && drv_hold[i] == 0) begin
          src_valid[i]        = 1'b1;
          src_last[i]         = drv_mem[i][drv_head[i] % DEPTH][8];
          src_data[i*8 +: 8]  = drv_mem[i][drv_head[i] % DEPTH][7:0];
        end else begin
          src_valid[i] = 1'b0;
          src_last[i]  = 1'b0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] pkt_bytes[NS][4][8];
  int         pkt_len[NS][4];
  bit         pkt_done[NS][4];
  int         pkt_n[NS];
  int         model_ptr = 0;
  logic [7:0] stage[$];

  logic [8:0] exp_q[$];
  logic [1:0] exp_gnt_q[$];
  int exp_pulses = 0;
  int pulse_cnt  = 0;

  // Queue a packet from the staged bytes; an incomplete packet never raises src_last.
  task automatic add_pkt(input int s, input bit complete);
    int p;
    p = pkt_n[s];
    for (int b = 0; b < stage.size(); b++) begin
      pkt_bytes[s][p][b] = stage[b];
      drv_mem[s][drv_tail[s] % DEPTH] = {complete && (b == stage.size() - 1), stage[b]};
      drv_tail[s]++;
    end
    pkt_len[s][p]  = stage.size();
    pkt_done[s][p] = complete;
    pkt_n[s]++;
    stage.delete();
  endtask

  task automatic add_rand_pkt(input int s, input int len);
    for (int b = 0; b < len; b++) stage.push_back(8'($urandom_range(0, 255)));
    add_pkt(s, 1'b1);
  endtask

  // Whole packets are served in round-robin order starting at the pointer; the pointer moves
  // to winner+1 after each packet, whether it ended normally or was revoked.
  task automatic run_model();
    int pidx[NS];
    int w;
    for (int i = 0; i < NS; i++) pidx[i] = 0;
    for (int iter = 0; iter < 64; iter++) begin
      w = -1;
      for (int k = 0; k < NS; k++) begin
        int c;
        c = (model_ptr + k) % NS;
        if (w < 0 && pidx[c] < pkt_n[c]) w = c;
      end
      if (w < 0) break;
      exp_gnt_q.push_back(2'(w));
`ifdef UART_TX_ARB_SRC_TAG_EN
      exp_q.push_back({1'b0, 8'hA0 | 8'(w)});
`endif
      for (int b = 0; b < pkt_len[w][pidx[w]]; b++)
        exp_q.push_back({pkt_done[w][pidx[w]] && (b == pkt_len[w][pidx[w]] - 1),
                         pkt_bytes[w][pidx[w]][b]});
      if (!pkt_done[w][pidx[w]]) exp_pulses++;
      model_ptr = (w + 1) % NS;
      pidx[w]++;
    end
    for (int i = 0; i < NS; i++) pkt_n[i] = 0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic       busy_prev;
    logic       last_pending;
    int         last_hs_cyc;
    logic [8:0] e;
    logic [1:0] eg;
    busy_prev = 1'b0; last_pending = 1'b0; last_hs_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_prev    = 1'b0;
        last_pending = 1'b0;
      end else begin
        if (last_pending) begin
          check("busy_after_last", busy, 1'b0);
          last_pending = 1'b0;
        end
        if (busy && !busy_prev) begin
          eg = (exp_gnt_q.size() != 0) ? exp_gnt_q.pop_front() : 2'bxx;
          check("grant_id", grant_id, eg);
        end
        busy_prev = busy;
        if (timeout_pulse) begin
          pulse_cnt++;
          check("tmo_gap", cyc - last_hs_cyc, TMO);
        end
        if (tx_valid && tx_ready) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'bx;
          check("tx_byte", tx_data, e[7:0]);
          last_hs_cyc = cyc + 1;
          if (e[8] === 1'b1) last_pending = 1'b1;
        end
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout_pulse", timeout_pulse, 1'b0);
    check("rst_src_ready", src_ready, 4'h0);
    for (int i = 0; i < NS; i++) begin
      drv_head[i] = drv_tail[i];
      drv_hold[i] = 0;
    end
    exp_q.delete();
    exp_gnt_q.delete();
    model_ptr  = 0;
    exp_pulses = 0;
    pulse_cnt  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic begin_scenario();
    @(posedge clk);
    #2;
    pulse_cnt  = 0;
    exp_pulses = 0;
    for (int i = 0; i < NS; i++) ready_cnt[i] = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 8000 && !(exp_q.size() == 0 && !busy && drv_empty())) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    check("gnt_q_empty", exp_gnt_q.size(), 0);
    check("tmo_pulses", pulse_cnt, exp_pulses);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < NS; i++) pkt_n[i] = 0;
    apply_reset();

    // Single source, three bytes.
    begin_scenario();
    stage.push_back(8'h11); stage.push_back(8'h22); stage.push_back(8'h33);
    add_pkt(0, 1'b1);
    run_model();
    wait_idle();
    check("src0_ready_pulses", ready_cnt[0], 3);

    // Contention from reset: 0, 1, 3.
    apply_reset();
    begin_scenario();
    add_rand_pkt(0, 2); add_rand_pkt(1, 2); add_rand_pkt(3, 2);
    run_model();
    wait_idle();

    // Fairness: src0 keeps re-requesting while src2 waits.
    apply_reset();
    begin_scenario();
    add_rand_pkt(0, 2); add_rand_pkt(0, 1); add_rand_pkt(0, 2);
    add_rand_pkt(2, 1); add_rand_pkt(2, 2);
    run_model();
    wait_idle();

    // Timeout: src1 stalls after one non-last byte, src2 pending.
    apply_reset();
    begin_scenario();
    stage.push_back(8'hC1);
    add_pkt(1, 1'b0);
    add_rand_pkt(2, 2);
    run_model();
    wait_idle();
    check("src1_ready_pulses", ready_cnt[1], 1);

    // Single-byte packet from src2 (tagged when the tag feature is built in).
    begin_scenario();
    stage.push_back(8'h5A);
    add_pkt(2, 1'b1);
    run_model();
    wait_idle();

    // Randomized packet mixes.
    for (int r = 0; r < 6; r++) begin
      bit any;
      begin_scenario();
      any = 1'b0;
      for (int s = 0; s < NS; s++) begin
        if ($urandom_range(0, 1) == 1) begin
          any = 1'b1;
          for (int p = 0; p < $urandom_range(1, 2); p++) add_rand_pkt(s, $urandom_range(1, 4));
        end
      end
      if (!any) add_rand_pkt(r % NS, $urandom_range(1, 4));
      run_model();
      wait_idle();
    end

    // Reset while a byte is held, then src0 must win first.
    begin_scenario();
    add_rand_pkt(1, 4); add_rand_pkt(3, 2);
    run_model();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_valid && !tx_ready) && n < 2000);
    check("mid_pkt_reached", tx_valid && !tx_ready, 1'b1);
    apply_reset();
    begin_scenario();
    add_rand_pkt(2, 2); add_rand_pkt(0, 3);
    run_model();
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
